float_op_sequencer: RTL

Command front-end between the `Serial2AXIS` command stream and a fixed-latency float arithmetic unit (`FloatMul`, `FloatSub`, `IntToFloat`-class pipelines). It parses packets of operand pairs from a 32-bit AXI-Stream and issues one operation per pair to the arithmetic unit. It captures each result after the unit's fixed latency, buffers it, and returns it on an outbound AXI-Stream with packet framing. A credit scheme makes downstream back-pressure stall the input side, so no result is ever lost.

---
 rtl/float_op_sequencer_if.sv | 38 +++
 rtl/float_op_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/float_op_sequencer_if.sv
`timescale 1ns/1ps
// Bundles the command stream, arithmetic-unit issue/result pins and result stream.
// No logic inside; timing is set entirely by the sequencer and the unit it drives.
// slave = sequencer view, master = command source / result sink / arithmetic unit.
interface float_op_sequencer_if #(
  parameter int FLOAT_WIDTH = 19
);
  // command stream
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic [31:0]            s_axis_tdata;
  // arithmetic unit issue / result
  logic [FLOAT_WIDTH-1:0] op_a;
  logic [FLOAT_WIDTH-1:0] op_b;
  logic [1:0]             op_code;
  logic                   op_valid;
  logic [FLOAT_WIDTH-1:0] op_result;
  // result stream
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic [31:0]            m_axis_tdata;
  // framing error pulse
  logic                   err;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, op_result, m_axis_tready,
    output s_axis_tready, op_a, op_b, op_code, op_valid,
           m_axis_tvalid, m_axis_tlast, m_axis_tdata, err
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, op_result, m_axis_tready,
    input  s_axis_tready, op_a, op_b, op_code, op_valid,
           m_axis_tvalid, m_axis_tlast, m_axis_tdata, err
  );
endinterface

// File: rtl/float_op_sequencer.sv
`timescale 1ns/1ps
// Parses operand-pair packets, issues one float op per pair, returns framed results.
// Latency: B-word handshake to m_axis_tvalid is OP_LATENCY+1 cycles (empty buffer).
// Backpressure: credit (ops in flight + buffered) caps at FIFO_DEPTH and stalls B-word accept.
module float_op_sequencer #(
  parameter int FLOAT_WIDTH = 19,
  parameter int OP_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                 aclk,
  input logic                 resetn,
  float_op_sequencer_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_OPA     = 2'd1;
  localparam logic [1:0] ST_OPB     = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]             state;
  logic                   rdy_en;
  logic [1:0]             hdr_code;
  logic [15:0]            remaining;
  logic [FLOAT_WIDTH-1:0] a_lat;
  logic                   op_last;

  logic [OP_LATENCY-1:0]  tag_vld;
  logic [OP_LATENCY-1:0]  tag_last;

  logic [FLOAT_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic [CW-1:0]          credit;

  logic                   s_hs;
  logic                   m_hs;
  logic                   issue;
  logic                   push;
  logic                   fifo_empty;
  logic [FLOAT_WIDTH:0]   head;
  logic [FLOAT_WIDTH-1:0] s_opnd;
  logic [15:0]            hdr_n;
  logic                   unused_tdata;

  assign s_opnd       = bus.s_axis_tdata[FLOAT_WIDTH-1:0];
  assign hdr_n        = bus.s_axis_tdata[15:0];
  assign unused_tdata = ^bus.s_axis_tdata;

  // Ready is a function of registered state only; rdy_en keeps it low through reset.
  assign bus.s_axis_tready = rdy_en & ((state != ST_OPB) | (credit < CW'(FIFO_DEPTH)));
  assign s_hs  = bus.s_axis_tvalid & bus.s_axis_tready;
  assign m_hs  = bus.m_axis_tvalid & bus.m_axis_tready;
  assign issue = s_hs & (state == ST_OPB);
  assign push  = tag_vld[OP_LATENCY-1];

  // Enable input acceptance from the first cycle after reset release.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  // Packet parser: header/operand FSM, operand registers, issue strobe and error pulse.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_HEADER;
      hdr_code     <= 2'd0;
      remaining    <= 16'd0;
      a_lat        <= '0;
      op_last      <= 1'b0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      bus.op_code  <= 2'd0;
      bus.op_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.op_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (s_hs) begin
        case (state)
          ST_HEADER: begin
            hdr_code  <= bus.s_axis_tdata[31:30];
            remaining <= hdr_n;
            if (hdr_n == 16'd0) begin
              // Empty packet is legal only when it is a single word.
              if (!bus.s_axis_tlast) begin
                bus.err <= 1'b1;
                state   <= ST_DISCARD;
              end
            end else begin
              state <= ST_OPA;
            end
          end
          ST_OPA: begin
            if (bus.s_axis_tlast) begin
              // Truncated: partial pair dropped, earlier results stay unframed.
              bus.err <= 1'b1;
              state   <= ST_HEADER;
            end else begin
              a_lat <= s_opnd;
              state <= ST_OPB;
            end
          end
          ST_OPB: begin
            bus.op_a     <= a_lat;
            bus.op_b     <= s_opnd;
            bus.op_code  <= hdr_code;
            bus.op_valid <= 1'b1;
            remaining    <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              op_last <= 1'b1;
              if (bus.s_axis_tlast) begin
                state <= ST_HEADER;
              end else begin
                bus.err <= 1'b1;
                state   <= ST_DISCARD;
              end
            end else begin
              op_last <= 1'b0;
              if (bus.s_axis_tlast) begin
                bus.err <= 1'b1;
                state   <= ST_HEADER;
              end else begin
                state <= ST_OPA;
              end
            end
          end
          default: begin
            if (bus.s_axis_tlast) state <= ST_HEADER;
          end
        endcase
      end
    end
  end

  // Tag pipeline mirrors the unit latency so the result is captured on the right edge.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else begin
      tag_vld[0]  <= bus.op_valid;
      tag_last[0] <= op_last;
      for (int i = 1; i < OP_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Credit: ops issued but not yet handed downstream; issue and pop together cancel.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      credit <= '0;
    end else if (issue && !m_hs) begin
      credit <= credit + CW'(1);
    end else if (!issue && m_hs) begin
      credit <= credit - CW'(1);
    end
  end

  // Result buffer pointers and occupancy; credit guarantees push never hits a full buffer.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (m_hs) rd_ptr <= rd_ptr + AW'(1);
      if (push && !m_hs)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && m_hs) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // Result storage: last flag kept alongside the result word.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {tag_last[OP_LATENCY-1], bus.op_result};
  end

  // Outbound stream: head entry zero-extended, forced to 0 while the buffer is empty.
  always_comb begin
    fifo_empty        = (fifo_cnt == '0);
    head              = mem[rd_ptr];
    bus.m_axis_tvalid = !fifo_empty;
    bus.m_axis_tdata  = 32'd0;
    bus.m_axis_tlast  = 1'b0;
    if (!fifo_empty) begin
      bus.m_axis_tdata = 32'(head[FLOAT_WIDTH-1:0]);
      bus.m_axis_tlast = head[FLOAT_WIDTH];
    end
  end

endmodule
